// File: rtl/collision_pkg.sv
// collision_pkg
//   Shared types and helpers for collision checking. The renderer debug
//   overlay reuses collision_box_t and overlap(), so both live here rather
//   than inside the checker.
//   Contents:
//     COLLISION_BOX_COUNT - detailed boxes per obstacle (mirrors the horizon
//                           block's obstacle box count)
//     collision_box_t     - one axis-aligned box in absolute screen coordinates
//     check_state_t       - collision_checker FSM states
//     overlap()           - strict-overlap test between two boxes
package collision_pkg;

    localparam int COLLISION_BOX_COUNT = 5;

    typedef struct packed {
        logic signed [10:0] x_pos;
        logic        [9:0]  y_pos;
        logic        [9:0]  width;
        logic        [9:0]  height;
    } collision_box_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OUTER,
        ST_INNER,
        ST_DONE
    } check_state_t;

    // Boxes that merely touch do not overlap (strict '<'). A box with zero
    // width or height never overlaps anything, which lets unused slots be
    // parked as all-zero boxes.
    function automatic logic overlap(input collision_box_t a, input collision_box_t b);
        logic signed [12:0] ax, ay, aw, ah;
        logic signed [12:0] bx, by, bw, bh;
        logic               hit;
        // 13-bit signed terms: sign-extend x, zero-extend the unsigned fields,
        // so x+width never wraps and negative x compares correctly.
        ax = {{2{a.x_pos[10]}}, a.x_pos};
        bx = {{2{b.x_pos[10]}}, b.x_pos};
        ay = {3'b000, a.y_pos};
        by = {3'b000, b.y_pos};
        aw = {3'b000, a.width};
        bw = {3'b000, b.width};
        ah = {3'b000, a.height};
        bh = {3'b000, b.height};
        hit = (ax < bx + bw) && (bx < ax + aw) &&
              (ay < by + bh) && (by < ay + ah);
        if (a.width == '0 || a.height == '0 || b.width == '0 || b.height == '0) begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/collision_checker_if.sv
// collision_checker_if
//   Request/response and box-data bundle between the game controller
//   (master) and collision_checker (slave).
//   Signals:
//     check          - single-cycle request to start a check
//     enable         - gates check (low during waiting / intro)
//     restart        - single-cycle pulse clearing crash while idle
//     trex_outer     - T-rex bounding box
//     trex_box[]     - T-rex detailed boxes
//     obstacle_outer - leftmost obstacle bounding box
//     obstacle_box[] - leftmost obstacle detailed boxes
//     busy           - check in progress
//     done           - single-cycle end-of-check pulse
//     crash          - sticky collision flag
interface collision_checker_if
    import collision_pkg::*;
#(
    parameter int TREX_BOXES     = 6,
    parameter int OBSTACLE_BOXES = COLLISION_BOX_COUNT
) ();

    logic           check;
    logic           enable;
    logic           restart;
    collision_box_t trex_outer;
    collision_box_t trex_box [TREX_BOXES];
    collision_box_t obstacle_outer;
    collision_box_t obstacle_box [OBSTACLE_BOXES];
    logic           busy;
    logic           done;
    logic           crash;

    modport master (
        output check, enable, restart,
        output trex_outer, trex_box, obstacle_outer, obstacle_box,
        input  busy, done, crash
    );

    modport slave (
        input  check, enable, restart,
        input  trex_outer, trex_box, obstacle_outer, obstacle_box,
        output busy, done, crash
    );

endinterface

// File: rtl/box_overlap.sv
// box_overlap
//   Combinational comparator for one pair of collision boxes.
//   Ports:
//     a, b - boxes to compare (absolute coordinates)
//     hit  - high when the boxes strictly overlap
module box_overlap
    import collision_pkg::*;
(
    input  collision_box_t a,
    input  collision_box_t b,
    output logic           hit
);

    assign hit = overlap(a, b);

endmodule

// File: rtl/collision_checker.sv
// collision_checker
//   On an accepted check, snapshots the T-rex and leftmost-obstacle boxes,
//   tests the outer bounding boxes, then scans detailed pairs (trex i,
//   obstacle j; j fastest) one per cycle. A hit ends the scan and sets the
//   sticky crash flag in the same cycle as done.
//   Ports:
//     clk - system clock
//     rst - synchronous active-high reset; aborts a check without done
//     bus - collision_checker_if slave modport (request, boxes, status)
module collision_checker
    import collision_pkg::*;
#(
    parameter int TREX_BOXES     = 6,
    parameter int OBSTACLE_BOXES = COLLISION_BOX_COUNT
) (
    input  logic                      clk,
    input  logic                      rst,
    collision_checker_if.slave        bus
);

    localparam int TI_W = (TREX_BOXES > 1)     ? $clog2(TREX_BOXES)     : 1;
    localparam int OJ_W = (OBSTACLE_BOXES > 1) ? $clog2(OBSTACLE_BOXES) : 1;
    localparam logic [TI_W-1:0] TI_LAST = TI_W'(TREX_BOXES - 1);
    localparam logic [OJ_W-1:0] OJ_LAST = OJ_W'(OBSTACLE_BOXES - 1);

    check_state_t    state;
    logic [TI_W-1:0] ti;
    logic [OJ_W-1:0] oj;
    logic            busy;
    logic            done;
    logic            crash;

    collision_box_t  snap_trex_outer;
    collision_box_t  snap_trex_box [TREX_BOXES];
    collision_box_t  snap_obstacle_outer;
    collision_box_t  snap_obstacle_box [OBSTACLE_BOXES];

    collision_box_t  cmp_a;
    collision_box_t  cmp_b;
    logic            pair_hit;
    logic            accept;
    logic            last_pair;

    // restart wins over a same-cycle check; a crashed game ignores check.
    assign accept    = (state == ST_IDLE) && bus.check && bus.enable &&
                       !crash && !bus.restart;
    assign last_pair = (ti == TI_LAST) && (oj == OJ_LAST);

    // Snapshot registers are pure data qualified by the FSM, so they carry
    // no reset.
    // NOTE: datapath storage that is always written before it is read needs
    // no reset; leaving it out keeps reset fan-out to control state only.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            snap_trex_outer     <= bus.trex_outer;
            snap_trex_box       <= bus.trex_box;
            snap_obstacle_outer <= bus.obstacle_outer;
            snap_obstacle_box   <= bus.obstacle_box;
        end
    end

    // One comparator shared by both phases: outer boxes in OUTER, the
    // current (i, j) pair otherwise.
    always_comb begin
        // NOTE: assign defaults first so every path drives the outputs and no
        // latch is inferred.
        cmp_a = snap_trex_outer;
        cmp_b = snap_obstacle_outer;
        if (state == ST_INNER) begin
            cmp_a = snap_trex_box[ti];
            cmp_b = snap_obstacle_box[oj];
        end
    end

    box_overlap u_box_overlap (
        .a   (cmp_a),
        .b   (cmp_b),
        .hit (pair_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            crash <= 1'b0;
            ti    <= '0;
            oj    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.restart) begin
                        crash <= 1'b0;
                    end else if (accept) begin
                        state <= ST_OUTER;
                        busy  <= 1'b1;
                        ti    <= '0;
                        oj    <= '0;
                    end
                end
                ST_OUTER: begin
                    if (pair_hit) begin
                        state <= ST_INNER;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_INNER: begin
                    if (pair_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        crash <= 1'b1;
                    end else if (last_pair) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (oj == OJ_LAST) begin
                        oj <= '0;
                        ti <= ti + 1'b1;
                    end else begin
                        oj <= oj + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.crash = crash;

endmodule

// File: tb/tb_collision_checker.sv
// tb_collision_checker
//   Directed-vector bench for collision_checker. Inputs change and outputs
//   are sampled on the falling edge; latency n means done is seen at the
//   n-th falling edge after the edge where check was sampled.
module tb_collision_checker;
    import collision_pkg::*;

    localparam int TB_TREX = 6;
    localparam int TB_OBS  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    collision_checker_if #(.TREX_BOXES(TB_TREX), .OBSTACLE_BOXES(TB_OBS)) bus ();

    collision_checker #(.TREX_BOXES(TB_TREX), .OBSTACLE_BOXES(TB_OBS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic collision_box_t mk(input int x, input int y, input int w, input int h);
        collision_box_t r;
        r.x_pos  = 11'(x);
        r.y_pos  = 10'(y);
        r.width  = 10'(w);
        r.height = 10'(h);
        return r;
    endfunction

    task automatic clear_inputs();
        bus.check          = 1'b0;
        bus.enable         = 1'b1;
        bus.restart        = 1'b0;
        bus.trex_outer     = mk(0, 0, 0, 0);
        bus.obstacle_outer = mk(0, 0, 0, 0);
        for (int i = 0; i < TB_TREX; i++) bus.trex_box[i] = mk(0, 0, 0, 0);
        for (int j = 0; j < TB_OBS; j++)  bus.obstacle_box[j] = mk(0, 0, 0, 0);
    endtask

    // kind 1: everything misses; kind 2: everything hits.
    task automatic apply_alt(input int kind);
        if (kind == 1) begin
            clear_inputs();
            bus.trex_outer     = mk(10, 100, 40, 40);
            bus.obstacle_outer = mk(300, 100, 20, 40);
        end else begin
            bus.trex_outer     = mk(50, 100, 20, 20);
            bus.obstacle_outer = mk(50, 100, 20, 20);
            for (int i = 0; i < TB_TREX; i++) bus.trex_box[i] = mk(50, 100, 20, 20);
            for (int j = 0; j < TB_OBS; j++)  bus.obstacle_box[j] = mk(50, 100, 20, 20);
        end
    endtask

    // Called at a falling edge. disturb_at: falling edge at which to act;
    // alt_kind 1/2 rewrites inputs and pulses check, 3 pulses restart.
    task automatic run_check(input string tag, input int exp_lat, input logic exp_crash,
                             input int disturb_at, input int alt_kind);
        int lat = 0;
        int busy_cnt = 0;
        bus.check = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.check   = 1'b0;
            bus.restart = 1'b0;
            if (n == disturb_at) begin
                if (alt_kind == 3) begin
                    bus.restart = 1'b1;
                end else begin
                    apply_alt(alt_kind);
                    bus.check = 1'b1;
                end
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_crash"}, bus.crash, exp_crash);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        @(negedge clk);
        bus.check   = 1'b0;
        bus.restart = 1'b0;
        check({tag, "_done_single"}, bus.done, 0);
        check({tag, "_back_idle"}, bus.busy, 0);
    endtask

    // Counts busy/done activity over a window; any activity is a failure.
    task automatic expect_quiet(input string tag, input int cycles);
        int act = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            bus.check   = 1'b0;
            bus.restart = 1'b0;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) act++;
        end
        check({tag, "_activity"}, act, 0);
    endtask

    task automatic do_restart(input string tag);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check({tag, "_crash_cleared"}, bus.crash, 0);
    endtask

    task automatic setup_pair(input int ti, input int oj);
        clear_inputs();
        bus.trex_outer       = mk(40, 90, 80, 80);
        bus.obstacle_outer   = mk(50, 100, 60, 60);
        bus.trex_box[ti]     = mk(50, 100, 20, 20);
        bus.obstacle_box[oj] = mk(60, 110, 20, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_crash", bus.crash, 0);

        // Disjoint outer boxes.
        bus.trex_outer     = mk(10, 100, 40, 40);
        bus.obstacle_outer = mk(300, 100, 20, 40);
        run_check("outer_miss", 2, 1'b0, 0, 0);

        // First detailed pair overlaps: k=0, latency 3.
        clear_inputs();
        bus.trex_outer      = mk(50, 100, 20, 20);
        bus.obstacle_outer  = mk(50, 100, 20, 20);
        bus.trex_box[0]     = mk(50, 100, 20, 20);
        bus.obstacle_box[0] = mk(50, 100, 20, 20);
        run_check("pair0_hit", 3, 1'b1, 0, 0);

        // crash blocks new checks; restart clears it.
        bus.check = 1'b1;
        expect_quiet("check_while_crash", 5);
        check("crash_held", bus.crash, 1);
        do_restart("restart_after_pair0");

        // Only pair (5,4): k=29, latency 32.
        setup_pair(5, 4);
        run_check("pair54_hit", 32, 1'b1, 0, 0);
        do_restart("restart_after_pair54");

        // Touching edges everywhere: full miss, latency 32.
        clear_inputs();
        bus.trex_outer     = mk(0, 0, 100, 100);
        bus.obstacle_outer = mk(0, 0, 100, 100);
        for (int i = 0; i < TB_TREX; i++) bus.trex_box[i] = mk(0, 0, 10, 10);
        for (int j = 0; j < TB_OBS; j++)  bus.obstacle_box[j] = mk(10, 0, 10, 10);
        run_check("touching_miss", 32, 1'b0, 0, 0);

        // Negative x -5 width 10 vs (0,0,5,5): overlap at pair 0.
        clear_inputs();
        bus.trex_outer      = mk(0, 0, 50, 50);
        bus.obstacle_outer  = mk(0, 0, 50, 50);
        bus.trex_box[0]     = mk(-5, 0, 10, 10);
        bus.obstacle_box[0] = mk(0, 0, 5, 5);
        run_check("negx_hit", 3, 1'b1, 0, 0);
        do_restart("restart_after_negx");

        // Negative x -10 width 10 ends exactly at 0: touching, miss.
        bus.trex_box[0] = mk(-10, 0, 10, 10);
        run_check("negx_touch_miss", 32, 1'b0, 0, 0);

        // Zero height on an otherwise coincident pair: miss.
        clear_inputs();
        bus.trex_outer      = mk(50, 100, 20, 20);
        bus.obstacle_outer  = mk(50, 100, 20, 20);
        bus.trex_box[0]     = mk(50, 100, 20, 0);
        bus.obstacle_box[0] = mk(50, 100, 20, 20);
        run_check("zero_height_miss", 32, 1'b0, 0, 0);

        // Snapshot: pair (2,3) k=13 latency 16; inputs turned to all-miss mid-scan.
        setup_pair(2, 3);
        run_check("snapshot_hit", 16, 1'b1, 5, 1);
        do_restart("restart_after_snapshot");

        // Snapshot: all-miss scan; inputs turned to all-hit and check re-pulsed.
        clear_inputs();
        bus.trex_outer     = mk(50, 100, 20, 20);
        bus.obstacle_outer = mk(50, 100, 20, 20);
        run_check("snapshot_miss", 32, 1'b0, 5, 2);

        // restart during a scan is ignored: crash still set at done.
        setup_pair(2, 3);
        run_check("restart_busy_ignored", 16, 1'b1, 5, 3);
        do_restart("restart_after_busy");

        // enable low: check ignored.
        setup_pair(0, 0);
        bus.enable = 1'b0;
        bus.check  = 1'b1;
        expect_quiet("enable_low", 5);
        bus.enable = 1'b1;

        // restart and check together in IDLE: check dropped.
        bus.restart = 1'b1;
        bus.check   = 1'b1;
        expect_quiet("restart_with_check", 5);
        check("restart_with_check_crash", bus.crash, 0);

        // Reset at +5 during a hitting scan: no done, no crash.
        setup_pair(5, 4);
        bus.check = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus.check = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("reset_abort", 40);
        check("reset_abort_crash", bus.crash, 0);
        run_check("after_reset_rescan", 32, 1'b1, 0, 0);
        do_restart("restart_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
